usb_serial_cmd_bridge: RTL and testbench
========================================

Name: usb_serial_cmd_bridge

Overview:
Command responder on the user side of the USB serial FIFO-PHY: drains host bytes from the rx FIFO, decodes read/write commands, runs one transaction on a simple strobe/ack bus master port, and pushes response bytes into the tx FIFO. Lets a USB host peek/poke the SoC bus over the serial link. Both FIFO ports are FWFT and clocked by clk_i on the user side.

Parameters:
ADDRWIDTH, 32, bus address width; multiple of 8, 8..32; sent LSB first, ADDRWIDTH/8 bytes.
DATAWIDTH, 32, bus data width; multiple of 8, 8..32; sent LSB first, DATAWIDTH/8 bytes.
TIMEOUT, 1024, bus ack timeout in cycles, >=2; used only with USB_SERIAL_CMD_BRIDGE_TIMEOUT_EN.

Ports:
clk_i  in  1  single clock for all logic.
rst_n_i  in  1  reset, asynchronous, active-low.
rx_pop_o  out  1  pop rx FIFO; byte on rx_data_i consumed this cycle.
rx_data_i  in  8  rx FIFO head byte, valid when rx_empty_i low.
rx_empty_i  in  1  rx FIFO empty.
tx_push_o  out  1  push tx_data_o into tx FIFO.
tx_data_o  out  8  response byte.
tx_full_i  in  1  tx FIFO full.
bus_stb_o  out  1  bus request; held until bus_ack_i.
bus_we_o  out  1  1=write, 0=read; stable while bus_stb_o.
bus_addr_o  out  ADDRWIDTH  bus address.
bus_data_o  out  DATAWIDTH  write data.
bus_data_i  in  DATAWIDTH  read data, sampled on bus_ack_i.
bus_ack_i  in  1  transaction complete.
busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; all outputs 0; address/data/byte counters 0.
- rx_pop_o = state needs a byte AND !rx_empty_i (combinational); byte captured same edge. Never pops when rx_empty_i.
- tx_push_o = state RESP AND !tx_full_i (combinational); never pushes while tx_full_i. One byte per cycle max.
- Command byte: 0x01 WRITE, 0x02 READ; any other -> RESP with single byte 0xEE, then IDLE.
- States:
  IDLE: pop byte; 0x01/0x02 -> ADDR (latch we), else -> RESP(0xEE).
  ADDR: pop ADDRWIDTH/8 bytes into bus_addr_o LSB first; last byte -> WDATA if write, else BUS.
  WDATA: pop DATAWIDTH/8 bytes into bus_data_o LSB first; last -> BUS.
  BUS: bus_stb_o=1 from first cycle in BUS; on cycle bus_ack_i=1: stb drops next cycle, read data latched -> RESP.
  RESP: write -> 1 byte 0xA5; read -> DATAWIDTH/8 bytes of latched read data, LSB first; after last push -> IDLE.
- bus_ack_i outside BUS ignored. bus_addr_o/bus_data_o/bus_we_o hold value from decode until next command overwrites them.
- Min latency, write, 32/32, FIFOs never stall: 9 pops over 9 cycles, stb next cycle; with ack in 1st BUS cycle, 0xA5 pushed cycle after ack.
- rx underrun mid-command: state waits indefinitely, no partial timeout (host resync by reset).
- tx full in RESP: stall, byte index held; no byte dropped or duplicated.
- Reset mid-transaction: bus_stb_o drops immediately (async), partial command discarded.
- Byte counter width clog2(max(ADDRWIDTH,DATAWIDTH)/8)+1; wraps to 0 on each state change.

Optional Feature:
USB_SERIAL_CMD_BRIDGE_TIMEOUT_EN: defined -> counter cleared on BUS entry, increments each BUS cycle without ack; reaching TIMEOUT-1 without ack drops bus_stb_o, -> RESP sending single byte 0xE0 (no data, even for read), then IDLE; ack on the same cycle as expiry wins (normal response). Undefined -> no counter, BUS waits forever for bus_ack_i; TIMEOUT unused.

Test Plan:
- Write: rx bytes 01 78 56 34 12 EF BE AD DE, ack after 3 cycles -> one bus write addr 0x12345678 data 0xDEADBEEF, stb high exactly until ack cycle, tx receives A5.
- Read: rx 02 00 10 00 00, bus_data_i=0xCAFEF00D with ack -> bus_we_o=0 addr 0x00001000, tx bytes 0D F0 FE CA in order, busy_o low after.
- Bad command: rx 7F then 02 04 00 00 00 -> tx EE, then normal read at 0x4 proceeds; 7F never reaches bus.
- Backpressure: read response with tx_full_i toggling 1/0 each cycle and rx_empty_i gaps between address bytes -> no push while full, no pop while empty, tx stream exactly 4 correct bytes.
- Timeout (macro on, TIMEOUT=16): read with no ack -> stb high 16 cycles then low, tx E0, next command accepted; macro off -> stb stays high 1000 cycles, no tx.
- Reset: assert rst_n_i low during BUS -> bus_stb_o, tx_push_o, rx_pop_o, busy_o 0 same cycle; after release, fresh write command completes with A5.

Source files
------------

// File: rtl/usb_serial_cmd_bridge.sv
// USB serial command bridge: drains host command bytes from the rx FIFO, runs one
// strobe/ack bus transaction and returns the response bytes through the tx FIFO.
// Optional bus ack timeout is enabled with USB_SERIAL_CMD_BRIDGE_TIMEOUT_EN.
module usb_serial_cmd_bridge #(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  output logic                 rx_pop_o,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_empty_i,
  output logic                 tx_push_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_full_i,
  output logic                 bus_stb_o,
  output logic                 bus_we_o,
  output logic [ADDRWIDTH-1:0] bus_addr_o,
  output logic [DATAWIDTH-1:0] bus_data_o,
  input  logic [DATAWIDTH-1:0] bus_data_i,
  input  logic                 bus_ack_i,
  output logic                 busy_o
);

  localparam int unsigned ABYTES = ADDRWIDTH / 8;
  localparam int unsigned DBYTES = DATAWIDTH / 8;
  localparam int unsigned MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
  localparam int unsigned CW     = $clog2(MAXB) + 1;

  localparam logic [CW-1:0] ALAST = CW'(ABYTES - 1);
  localparam logic [CW-1:0] DLAST = CW'(DBYTES - 1);

  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] RSP_WR  = 8'hA5;
  localparam logic [7:0] RSP_BAD = 8'hEE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BUS   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        resp_last_q;
  logic [DATAWIDTH-1:0] resp_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic                 we_q;
  logic                 stb_q;
  logic                 busy_q;
  logic                 cmd_ok;
  logic                 pop_c;
  logic                 push_c;

  // Reset asserts asynchronously and releases two clocks after rst_n_i rises.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign cmd_ok = (rx_data_i == CMD_WR) || (rx_data_i == CMD_RD);

`ifdef USB_SERIAL_CMD_BRIDGE_TIMEOUT_EN
  localparam int unsigned   TW    = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    RSP_TMO = 8'hE0;

  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  // Ack wait counter, cleared whenever the bus phase is not active.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                tmo_q <= '0;
    else if (state_q != S_BUS) tmo_q <= '0;
    else if (!bus_ack_i)       tmo_q <= tmo_q + TW'(1);
  end

  assign tmo_hit = (state_q == S_BUS) && !bus_ack_i && (tmo_q == TLAST);
`else
  // TIMEOUT has no effect without the timeout feature.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT < 2);
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and the FIFO handshake strobes.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    push_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_empty_i) begin
          pop_c   = 1'b1;
          state_d = cmd_ok ? S_ADDR : S_RESP;
        end
      end
      S_ADDR: begin
        if (!rx_empty_i) begin
          pop_c = 1'b1;
          if (cnt_q == ALAST) state_d = we_q ? S_WDATA : S_BUS;
        end
      end
      S_WDATA: begin
        if (!rx_empty_i) begin
          pop_c = 1'b1;
          if (cnt_q == DLAST) state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (bus_ack_i) state_d = S_RESP;
`ifdef USB_SERIAL_CMD_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) state_d = S_RESP;
`endif
      end
      S_RESP: begin
        if (!tx_full_i) begin
          push_c = 1'b1;
          if (cnt_q == resp_last_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO strobes are silenced while the bridge is held in reset.
  assign rx_pop_o  = pop_c & rst_n;
  assign tx_push_o = push_c & rst_n;

  // Byte counter, command fields and the outgoing response bytes.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      resp_last_q <= '0;
      resp_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      stb_q  <= (state_d == S_BUS);
      busy_q <= (state_d != S_IDLE);

      if (state_d != state_q)  cnt_q <= '0;
      else if (pop_c || push_c) cnt_q <= cnt_q + CW'(1);

      case (state_q)
        S_IDLE: begin
          if (pop_c) begin
            if (cmd_ok) begin
              we_q <= (rx_data_i == CMD_WR);
            end else begin
              resp_q      <= DATAWIDTH'(RSP_BAD);
              resp_last_q <= '0;
            end
          end
        end
        S_ADDR: begin
          if (pop_c) begin
            for (int unsigned i = 0; i < ABYTES; i++) begin
              if (cnt_q == CW'(i)) addr_q[i*8 +: 8] <= rx_data_i;
            end
          end
        end
        S_WDATA: begin
          if (pop_c) begin
            for (int unsigned i = 0; i < DBYTES; i++) begin
              if (cnt_q == CW'(i)) wdata_q[i*8 +: 8] <= rx_data_i;
            end
          end
        end
        S_BUS: begin
          if (bus_ack_i) begin
            if (we_q) begin
              resp_q      <= DATAWIDTH'(RSP_WR);
              resp_last_q <= '0;
            end else begin
              resp_q      <= bus_data_i;
              resp_last_q <= DLAST;
            end
          end
`ifdef USB_SERIAL_CMD_BRIDGE_TIMEOUT_EN
          else if (tmo_hit) begin
            resp_q      <= DATAWIDTH'(RSP_TMO);
            resp_last_q <= '0;
          end
`endif
        end
        S_RESP: begin
          // Shift the next response byte down; a stalled push holds it in place.
          if (push_c) resp_q <= resp_q >> 8;
        end
        default: ;
      endcase
    end
  end

  assign tx_data_o  = resp_q[7:0];
  assign bus_stb_o  = stb_q;
  assign bus_we_o   = we_q;
  assign bus_addr_o = addr_q;
  assign bus_data_o = wdata_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_usb_serial_cmd_bridge.sv
// Randomized self-checking bench for usb_serial_cmd_bridge: FIFO and bus models
// drive the bridge and a command-level reference predicts every response.
`timescale 1ns/1ps
module tb_usb_serial_cmd_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int AB  = AW / 8;
  localparam int DB  = DW / 8;
  localparam int TMO = 16;

  logic          clk;
  logic          rst_n_i;
  logic          rx_pop_o;
  logic [7:0]    rx_data_i;
  logic          rx_empty_i;
  logic          tx_push_o;
  logic [7:0]    tx_data_o;
  logic          tx_full_i;
  logic          bus_stb_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_data_o;
  logic [DW-1:0] bus_data_i;
  logic          bus_ack_i;
  logic          busy_o;

  usb_serial_cmd_bridge #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .rx_pop_o   (rx_pop_o),
    .rx_data_i  (rx_data_i),
    .rx_empty_i (rx_empty_i),
    .tx_push_o  (tx_push_o),
    .tx_data_o  (tx_data_o),
    .tx_full_i  (tx_full_i),
    .bus_stb_o  (bus_stb_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_data_o (bus_data_o),
    .bus_data_i (bus_data_i),
    .bus_ack_i  (bus_ack_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];

  int cyc = 0;
  int gap_pct = 0;
  int full_pct = 0;
  bit full_toggle = 0;
  int ack_delay = -1;
  logic [DW-1:0] rdata = '0;

  int bus_n = 0;
  int stb_cycles = 0;
  bit stb_prev = 0;
  bit acked_prev = 0;
  logic [AW-1:0] seen_addr = '0;
  logic [DW-1:0] seen_wdata = '0;
  logic seen_we = 0;
  int first_pop_cyc = -1;
  int first_push_cyc = -1;
  int stb_rise_cyc = -1;
  int ack_cyc = -1;
  int pop_empty_err = 0;
  int push_full_err = 0;
  int stb_unstable_err = 0;
  int stb_after_ack_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive FIFO/bus inputs after the falling edge, sample just after.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    rx_empty_i = (rx_q.size() == 0) || ($urandom_range(0, 99) < gap_pct);
    rx_data_i  = rx_empty_i ? 8'($urandom) : rx_q[0];
    tx_full_i  = full_toggle ? cyc[0] : ($urandom_range(0, 99) < full_pct);
    if (bus_stb_o && !stb_prev) begin
      bus_n++;
      stb_cycles   = 0;
      stb_rise_cyc = cyc;
      seen_addr    = bus_addr_o;
      seen_we      = bus_we_o;
      seen_wdata   = bus_data_o;
    end else if (bus_stb_o) begin
      if (bus_addr_o !== seen_addr || bus_we_o !== seen_we ||
          (seen_we && bus_data_o !== seen_wdata)) stb_unstable_err++;
    end
    if (bus_stb_o && acked_prev) stb_after_ack_err++;
    bus_ack_i  = bus_stb_o && (ack_delay >= 0) && (stb_cycles == ack_delay);
    bus_data_i = bus_ack_i ? rdata : DW'($urandom);
    if (bus_ack_i) ack_cyc = cyc;
    #1;
    if (rx_pop_o) begin
      if (rx_empty_i) pop_empty_err++;
      else begin
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        void'(rx_q.pop_front());
      end
    end
    if (tx_push_o) begin
      if (tx_full_i) push_full_err++;
      else begin
        if (first_push_cyc < 0) first_push_cyc = cyc;
        tx_got.push_back(tx_data_o);
      end
    end
    if (bus_stb_o) stb_cycles++;
    stb_prev   = bus_stb_o;
    acked_prev = bus_ack_i;
  endtask

  // Send one command and compare the bus access and tx bytes with the reference.
  task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rd,
                         input int delay, input bit expect_tmo);
    logic [7:0] exp_tx[$];
    bit valid;
    bit wr;
    int n0;
    int budget;
    bool_quiet: begin end
    valid = (cmd == 8'h01) || (cmd == 8'h02);
    wr    = (cmd == 8'h01);
    n0    = bus_n;
    rdata = rd;
    ack_delay = delay;
    first_pop_cyc = -1;
    first_push_cyc = -1;
    tx_got.delete();
    rx_q.push_back(cmd);
    if (valid) begin
      for (int i = 0; i < AB; i++) rx_q.push_back(addr[8*i +: 8]);
      if (wr) for (int i = 0; i < DB; i++) rx_q.push_back(wdata[8*i +: 8]);
    end
    if (!valid)          exp_tx.push_back(8'hEE);
    else if (expect_tmo) exp_tx.push_back(8'hE0);
    else if (wr)         exp_tx.push_back(8'hA5);
    else for (int i = 0; i < DB; i++) exp_tx.push_back(rd[8*i +: 8]);

    budget = 0;
    do begin
      cycle();
      budget++;
    end while (!(tx_got.size() >= exp_tx.size() && rx_q.size() == 0 && !busy_o) && budget < 2000);

    check($sformatf("%s_done", tag), 64'(budget < 2000), 64'(1));
    check($sformatf("%s_tx_len", tag), 64'(tx_got.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 64'(tx_got[i]), 64'(exp_tx[i]));
    check($sformatf("%s_bus_n", tag), 64'(bus_n - n0), 64'(valid ? 1 : 0));
    if (valid) begin
      check($sformatf("%s_addr", tag), 64'(seen_addr), 64'(addr));
      check($sformatf("%s_we", tag), 64'(seen_we), 64'(wr));
      if (wr) check($sformatf("%s_wdata", tag), 64'(seen_wdata), 64'(wdata));
      check($sformatf("%s_stb_len", tag), 64'(stb_cycles), 64'(expect_tmo ? TMO : delay + 1));
      if (gap_pct == 0 && full_pct == 0 && !full_toggle && !expect_tmo) begin
        check($sformatf("%s_stb_lat", tag), 64'(stb_rise_cyc - first_pop_cyc),
              64'(1 + AB + (wr ? DB : 0)));
        check($sformatf("%s_resp_lat", tag), 64'(first_push_cyc - ack_cyc), 64'(1));
      end
    end
    check($sformatf("%s_idle", tag), 64'(busy_o), 64'(0));
  endtask

  // Hold a read in the bus phase, then reset in the middle of it.
  task automatic reset_in_bus(input int hold);
    int b;
    rdata = 32'h1111_2222;
    ack_delay = -1;
    tx_got.delete();
    rx_q.push_back(8'h02);
    for (int i = 0; i < AB; i++) rx_q.push_back(8'(8'h40 + i));
    b = 0;
    do begin
      cycle();
      b++;
    end while (!stb_prev && b < 100);
    check("stall_stb_seen", 64'(stb_prev), 64'(1));
    repeat (hold - 1) cycle();
    check("stall_stb_len", 64'(stb_cycles), 64'(hold));
    check("stall_no_tx", 64'(tx_got.size()), 64'(0));
    rst_n_i    = 1'b0;
    rx_empty_i = 1'b0;
    rx_data_i  = 8'h01;
    #1;
    check("rst_stb", 64'(bus_stb_o), 64'(0));
    check("rst_push", 64'(tx_push_o), 64'(0));
    check("rst_pop", 64'(rx_pop_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    rx_q.delete();
    rx_empty_i = 1'b1;
    stb_prev   = 1'b0;
    acked_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    repeat (4) cycle();
  endtask

  initial begin
    logic [7:0] c;
    int r;
    rst_n_i    = 1'b0;
    rx_empty_i = 1'b1;
    rx_data_i  = 8'h00;
    tx_full_i  = 1'b0;
    bus_ack_i  = 1'b0;
    bus_data_i = '0;

    repeat (3) @(negedge clk);
    rx_empty_i = 1'b0;
    rx_data_i  = 8'h01;
    #1;
    check("reset_pop", 64'(rx_pop_o), 64'(0));
    check("reset_push", 64'(tx_push_o), 64'(0));
    check("reset_stb", 64'(bus_stb_o), 64'(0));
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_txdata", 64'(tx_data_o), 64'(0));
    check("reset_addr", 64'(bus_addr_o), 64'(0));
    check("reset_wdata", 64'(bus_data_o), 64'(0));
    check("reset_we", 64'(bus_we_o), 64'(0));
    rx_empty_i = 1'b1;
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (4) cycle();

    run_txn("write", 8'h01, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 3, 0);
    run_txn("read", 8'h02, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 0, 0);
    run_txn("bad", 8'h7F, 32'h0, 32'h0, 32'h0, 0, 0);
    run_txn("read4", 8'h02, 32'h0000_0004, 32'h0, 32'h8765_4321, 1, 0);

    gap_pct = 40;
    full_toggle = 1;
    run_txn("bp_read", 8'h02, 32'hA5A5_0F0F, 32'h0, 32'h0102_0304, 2, 0);
    full_toggle = 0;

    for (int n = 0; n < 40; n++) begin
      gap_pct  = $urandom_range(0, 50);
      full_pct = $urandom_range(0, 50);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        c = 8'($urandom);
        if (c == 8'h01 || c == 8'h02) c = 8'h7F;
      end else c = (r < 5) ? 8'h01 : 8'h02;
      run_txn($sformatf("rnd%0d", n), c, AW'($urandom), DW'($urandom), DW'($urandom),
              $urandom_range(0, 6), 0);
    end
    gap_pct = 0;
    full_pct = 0;

`ifdef USB_SERIAL_CMD_BRIDGE_TIMEOUT_EN
    run_txn("tmo", 8'h02, 32'h0000_0100, 32'h0, 32'h5555_AAAA, -1, 1);
    run_txn("after_tmo", 8'h02, 32'h0000_0200, 32'h0, 32'h1357_9BDF, 0, 0);
    reset_in_bus(5);
`else
    reset_in_bus(1000);
`endif
    run_txn("post_rst_write", 8'h01, 32'h0BAD_F00D, 32'h7654_3210, 32'h0, 0, 0);

    check("pop_while_empty", 64'(pop_empty_err), 64'(0));
    check("push_while_full", 64'(push_full_err), 64'(0));
    check("stb_fields_stable", 64'(stb_unstable_err), 64'(0));
    check("stb_after_ack", 64'(stb_after_ack_err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
